cache_axi_bridge: RTL and testbench

- Downstream stage of the cache miss/uncache port.
- Converts the cache's rd_req/ret_* and wr_req/wr_data line interface into an AXI4 master with one outstanding read and one outstanding write.
- Serialises 128-bit line writebacks into 4-beat INCR bursts and returns read bursts beat-by-beat.
- Feeds the top-level AXI crossbar.

---
 rtl/cache_axi_bridge_pkg.sv | 29 ++
 rtl/cache_axi_bridge_if.sv | 60 ++++++
 rtl/cache_axi_bridge_wbeat_gen.sv | 52 +++++
 rtl/cache_axi_bridge.sv | 211 +++++++++++++++++++++
 tb/tb_cache_axi_bridge.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_axi_bridge_pkg.sv
// Shared types and constants for the cache-to-AXI bridge.
// Request type codes, AXI burst/size values and FSM state encodings.
package cache_axi_pkg;

    localparam logic [2:0] RD_BYTE = 3'b000;
    localparam logic [2:0] RD_HALF = 3'b001;
    localparam logic [2:0] RD_WORD = 3'b010;
    localparam logic [2:0] RD_LINE = 3'b100;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'd2;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_BUSY = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    function automatic logic is_line(input logic [2:0] t);
        return t == RD_LINE;
    endfunction

endpackage

// File: rtl/cache_axi_bridge_if.sv
// AXI4 master-side bundle between the bridge and the crossbar.
// The bridge uses the master modport, the interconnect the slave modport.
interface cache_axi_bridge_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    logic [31:0]       rdata;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;

    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rlast, rvalid,
        output rready,
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bvalid,
        output bready
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rlast, rvalid,
        input  rready,
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bvalid,
        input  bready
    );

endinterface

// File: rtl/cache_axi_bridge_wbeat_gen.sv
// W-channel beat generator: beat counter and word select
// over the latched cache line.
module axi_wbeat_gen #(
    parameter int LINE_WORDS = 4,
    parameter int CW         = $clog2(LINE_WORDS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    advance,
    input  logic [32*LINE_WORDS-1:0] line_data,
    input  logic [CW-1:0]           len,
    input  logic                    line,
    input  logic [3:0]              strobe,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [31:0]   words [LINE_WORDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (advance) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < LINE_WORDS; i++) begin
            words[i] = line_data[32*i +: 32];
        end
    end

    // Word writes carry their own strobe; line beats are always full.
    assign wdata = words[cnt_q];
    assign wstrb = line ? 4'hf : strobe;
    assign wlast = (cnt_q == len);

endmodule

// File: rtl/cache_axi_bridge.sv
// Cache miss/uncache port to AXI4 master bridge with one
// outstanding read and one outstanding write.
module cache_axi_bridge
    import cache_axi_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    rd_req,
    input  logic [2:0]              rd_type,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic                    rd_rdy,
    output logic                    ret_valid,
    output logic                    ret_last,
    output logic [31:0]             ret_data,

    input  logic                    wr_req,
    input  logic [2:0]              wr_type,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [3:0]              wr_wstrb,
    input  logic [32*LINE_WORDS-1:0] wr_data,
    output logic                    wr_rdy,

    cache_axi_bridge_if.master      axi
);

    localparam int CW = $clog2(LINE_WORDS);
    localparam int LW = 32 * LINE_WORDS;

    r_state_t          r_q, r_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [7:0]        arlen_q, arlen_d;

    w_state_t          w_q, w_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [LW-1:0]     wbuf_q, wbuf_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              wline_q, wline_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;

    logic              rd_conflict;
    logic              w_start;
    logic              aw_hs;
    logic              w_hs;
    logic [31:0]       beat_data;
    logic [3:0]        beat_strb;
    logic              beat_last;

    // A refill must not overtake a dirty writeback of the same line.
    assign rd_conflict = (w_q != W_IDLE) &&
                         (rd_addr[ADDR_W-1:4] == waddr_q[ADDR_W-1:4]);

    assign rd_rdy  = !reset && (r_q == R_IDLE) && !rd_conflict;
    assign wr_rdy  = !reset && (w_q == W_IDLE);
    assign w_start = wr_req && wr_rdy;
    assign aw_hs   = axi.awvalid && axi.awready;
    assign w_hs    = axi.wvalid && axi.wready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q      <= R_IDLE;
            araddr_q <= '0;
            arlen_q  <= '0;
        end else begin
            r_q      <= r_d;
            araddr_q <= araddr_d;
            arlen_q  <= arlen_d;
        end
    end

    always_comb begin
        r_d      = r_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        unique case (r_q)
            R_IDLE: begin
                if (rd_req && rd_rdy) begin
                    araddr_d = rd_addr;
                    arlen_d  = is_line(rd_type) ? 8'(LINE_WORDS-1) : 8'd0;
                    r_d      = R_AR;
                end
            end
            R_AR: begin
                if (axi.arready) r_d = R_DATA;
            end
            R_DATA: begin
                if (axi.rvalid && axi.rlast) r_d = R_IDLE;
            end
            default: r_d = R_IDLE;
        endcase
    end

    always_comb begin
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        unique case (r_q)
            R_AR:    axi.arvalid = 1'b1;
            R_DATA:  axi.rready  = 1'b1;
            default: ;
        endcase
    end

    assign axi.araddr  = araddr_q;
    assign axi.arlen   = arlen_q;
    assign axi.arsize  = AXI_SIZE_4B;
    assign axi.arburst = AXI_BURST_INCR;

    // Read data is forwarded combinationally to avoid added latency.
    assign ret_valid = axi.rready && axi.rvalid;
    assign ret_last  = ret_valid && axi.rlast;
    assign ret_data  = axi.rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            w_q       <= W_IDLE;
            waddr_q   <= '0;
            wbuf_q    <= '0;
            wstrb_q   <= '0;
            wline_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            w_q       <= w_d;
            waddr_q   <= waddr_d;
            wbuf_q    <= wbuf_d;
            wstrb_q   <= wstrb_d;
            wline_q   <= wline_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        w_d       = w_q;
        waddr_d   = waddr_q;
        wbuf_d    = wbuf_q;
        wstrb_d   = wstrb_q;
        wline_d   = wline_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        unique case (w_q)
            W_IDLE: begin
                if (w_start) begin
                    waddr_d   = wr_addr;
                    wbuf_d    = wr_data;
                    wstrb_d   = wr_wstrb;
                    wline_d   = is_line(wr_type);
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_d       = W_BUSY;
                end
            end
            W_BUSY: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs && beat_last) w_done_d = 1'b1;
                // AW and W complete independently, possibly together.
                if ((aw_done_q || aw_hs) &&
                    (w_done_q || (w_hs && beat_last))) begin
                    w_d = W_RESP;
                end
            end
            W_RESP: begin
                if (axi.bvalid) w_d = W_IDLE;
            end
            default: w_d = W_IDLE;
        endcase
    end

    always_comb begin
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        unique case (w_q)
            W_BUSY: begin
                axi.awvalid = !aw_done_q;
                axi.wvalid  = !w_done_q;
            end
            W_RESP:  axi.bready = 1'b1;
            default: ;
        endcase
    end

    assign axi.awaddr  = waddr_q;
    assign axi.awlen   = wline_q ? 8'(LINE_WORDS-1) : 8'd0;
    assign axi.awsize  = AXI_SIZE_4B;
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.wdata   = beat_data;
    assign axi.wstrb   = beat_strb;
    assign axi.wlast   = beat_last;

    axi_wbeat_gen #(
        .LINE_WORDS (LINE_WORDS)
    ) u_wbeat (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_start),
        .advance   (w_hs),
        .line_data (wbuf_q),
        .len       (wline_q ? CW'(LINE_WORDS-1) : CW'(0)),
        .line      (wline_q),
        .strobe    (wstrb_q),
        .wdata     (beat_data),
        .wstrb     (beat_strb),
        .wlast     (beat_last)
    );

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Self-checking bench for cache_axi_bridge: directed and randomized
// reads/writes against a spec-level model of bursts and beats.
module tb_cache_axi_bridge;
    import cache_axi_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_axi_bridge_if #(.ADDR_W(32)) axi ();

    cache_axi_bridge #(
        .LINE_WORDS (4),
        .ADDR_W     (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_req    (rd_req),
        .rd_type   (rd_type),
        .rd_addr   (rd_addr),
        .rd_rdy    (rd_rdy),
        .ret_valid (ret_valid),
        .ret_last  (ret_last),
        .ret_data  (ret_data),
        .wr_req    (wr_req),
        .wr_type   (wr_type),
        .wr_addr   (wr_addr),
        .wr_wstrb  (wr_wstrb),
        .wr_data   (wr_data),
        .wr_rdy    (wr_rdy),
        .axi       (axi)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int beats_of(input logic [2:0] t);
        return (t == 3'b100) ? 4 : 1;
    endfunction

    function automatic logic [31:0] word_of(input logic [127:0] d,
                                            input int i);
        return d[32*i +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic rd_issue(input logic [31:0] a, input logic [2:0] t);
        rd_req  = 1'b1;
        rd_type = t;
        rd_addr = a;
        settle();
        chk("rd_rdy_accept", rd_rdy, 1);
        tick();
        rd_req = 1'b0;
        settle();
        chk("arvalid_up", axi.arvalid, 1);
        chk("araddr", axi.araddr, a);
        chk("arlen", axi.arlen, 128'(beats_of(t) - 1));
        chk("arsize", axi.arsize, 2);
        chk("arburst", axi.arburst, 1);
    endtask

    task automatic rd_ar(input int delay, input logic [31:0] a);
        for (int d = 0; d < delay; d++) begin
            chk("arvalid_hold", axi.arvalid, 1);
            chk("araddr_hold", axi.araddr, a);
            tick();
            settle();
        end
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        settle();
        chk("arvalid_drop", axi.arvalid, 0);
    endtask

    task automatic rd_beats(input logic [2:0] t, input logic [31:0] d [4],
                            input int maxgap, input logic exp_rdy);
        int n;
        n = beats_of(t);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = $urandom_range(0, maxgap);
            for (int g = 0; g < gap; g++) begin
                chk("rready_gap", axi.rready, 1);
                chk("ret_valid_gap", ret_valid, 0);
                tick();
                settle();
            end
            axi.rvalid = 1'b1;
            axi.rdata  = d[i];
            axi.rlast  = (i == n - 1);
            settle();
            chk("ret_valid", ret_valid, 1);
            chk("ret_data", ret_data, d[i]);
            chk("ret_last", ret_last, (i == n - 1));
            chk("rd_rdy_busy", rd_rdy, 0);
            tick();
            axi.rvalid = 1'b0;
            axi.rlast  = 1'b0;
            settle();
        end
        chk("rd_rdy_after_last", rd_rdy, exp_rdy);
        chk("rready_after_last", axi.rready, 0);
    endtask

    task automatic wr_issue(input logic [31:0] a, input logic [2:0] t,
                            input logic [3:0] s, input logic [127:0] d);
        wr_req   = 1'b1;
        wr_type  = t;
        wr_addr  = a;
        wr_wstrb = s;
        wr_data  = d;
        settle();
        chk("wr_rdy_accept", wr_rdy, 1);
        tick();
        wr_req = 1'b0;
        settle();
        chk("wr_rdy_busy", wr_rdy, 0);
    endtask

    task automatic wr_run(input logic [31:0] a, input logic [2:0] t,
                          input logic [3:0] s, input logic [127:0] d,
                          input bit hold_aw);
        int  n;
        int  k;
        int  cyc;
        int  aw_cnt;
        bit  aw_seen;
        bit  w_fin;
        n = beats_of(t);
        k = 0;
        cyc = 0;
        aw_cnt = 0;
        aw_seen = 1'b0;
        w_fin = 1'b0;
        while (!(aw_seen && w_fin) && cyc < 100) begin
            axi.awready = hold_aw ? w_fin : 1'($urandom_range(0, 1));
            axi.wready  = 1'($urandom_range(0, 1));
            settle();
            chk("bready_busy", axi.bready, 0);
            chk("awvalid_model", axi.awvalid, !aw_seen);
            chk("wvalid_model", axi.wvalid, !w_fin);
            if (axi.awvalid && axi.awready) begin
                chk("awaddr", axi.awaddr, a);
                chk("awlen", axi.awlen, 128'(n - 1));
                chk("awsize", axi.awsize, 2);
                chk("awburst", axi.awburst, 1);
                aw_seen = 1'b1;
                aw_cnt++;
            end
            if (axi.wvalid && axi.wready) begin
                chk("wdata", axi.wdata, word_of(d, k));
                chk("wstrb", axi.wstrb, (t == 3'b100) ? 4'hf : s);
                chk("wlast", axi.wlast, (k == n - 1));
                if (k == n - 1) w_fin = 1'b1;
                k++;
            end
            tick();
            cyc++;
        end
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        chk("wr_done_in_time", (aw_seen && w_fin), 1);
        chk("aw_count", aw_cnt, 1);
        chk("w_beat_count", k, n);
        settle();
        chk("bready_resp", axi.bready, 1);
        chk("awvalid_resp", axi.awvalid, 0);
        chk("wvalid_resp", axi.wvalid, 0);
        chk("wr_rdy_resp", wr_rdy, 0);
    endtask

    task automatic wr_resp(input int delay);
        for (int i = 0; i < delay; i++) begin
            chk("bready_wait", axi.bready, 1);
            chk("wr_rdy_wait", wr_rdy, 0);
            tick();
            settle();
        end
        axi.bvalid = 1'b1;
        tick();
        axi.bvalid = 1'b0;
        settle();
        chk("wr_rdy_after_b", wr_rdy, 1);
        chk("bready_after_b", axi.bready, 0);
    endtask

    initial begin
        logic [31:0]  rd [4];
        logic [127:0] wd;
        logic [2:0]   types [5];
        logic [2:0]   t;
        logic [31:0]  a;

        types = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b011};
        reset = 1'b1;
        rd_req = 1'b0;
        rd_type = 3'b0;
        rd_addr = '0;
        wr_req = 1'b0;
        wr_type = 3'b0;
        wr_addr = '0;
        wr_wstrb = '0;
        wr_data = '0;
        axi.arready = 1'b0;
        axi.rdata = '0;
        axi.rlast = 1'b0;
        axi.rvalid = 1'b0;
        axi.awready = 1'b0;
        axi.wready = 1'b0;
        axi.bvalid = 1'b0;

        repeat (3) tick();
        settle();
        chk("rst_rd_rdy", rd_rdy, 0);
        chk("rst_wr_rdy", wr_rdy, 0);
        reset = 1'b0;
        tick();
        settle();
        chk("idle_arvalid", axi.arvalid, 0);
        chk("idle_awvalid", axi.awvalid, 0);
        chk("idle_wvalid", axi.wvalid, 0);
        chk("idle_rready", axi.rready, 0);
        chk("idle_bready", axi.bready, 0);
        chk("idle_ret_valid", ret_valid, 0);
        chk("idle_ret_last", ret_last, 0);
        chk("idle_rd_rdy", rd_rdy, 1);
        chk("idle_wr_rdy", wr_rdy, 1);

        rd = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        tick();
        rd_issue(32'h1c000040, RD_LINE);
        rd_ar(2, 32'h1c000040);
        rd_beats(RD_LINE, rd, 2, 1'b1);

        tick();
        wd = {$urandom, $urandom, $urandom, $urandom};
        wr_issue(32'hbfaf8004, RD_WORD, 4'b0011, wd);
        wr_run(32'hbfaf8004, RD_WORD, 4'b0011, wd, 1'b0);
        wr_resp(3);

        tick();
        wd = 128'h44444444_33333333_22222222_11111111;
        wr_issue(32'h00001230, RD_LINE, 4'h0, wd);
        wr_run(32'h00001230, RD_LINE, 4'h0, wd, 1'b1);
        wr_resp(2);

        tick();
        wd = {$urandom, $urandom, $urandom, $urandom};
        wr_issue(32'h00002000, RD_LINE, 4'h0, wd);
        rd_type = RD_LINE;
        rd_addr = 32'h00002008;
        settle();
        chk("conflict_busy", rd_rdy, 0);
        wr_run(32'h00002000, RD_LINE, 4'h0, wd, 1'b0);
        chk("conflict_resp", rd_rdy, 0);
        wr_resp(2);
        chk("conflict_clear", rd_rdy, 1);
        for (int i = 0; i < 4; i++) rd[i] = $urandom;
        tick();
        rd_issue(32'h00002008, RD_LINE);
        rd_ar(0, 32'h00002008);
        rd_beats(RD_LINE, rd, 1, 1'b1);

        tick();
        wd = {$urandom, $urandom, $urandom, $urandom};
        wr_issue(32'h00003000, RD_LINE, 4'h0, wd);
        tick();
        rd_issue(32'h00004010, RD_LINE);
        chk("overlap_awvalid", axi.awvalid, 1);
        chk("overlap_wvalid", axi.wvalid, 1);
        for (int i = 0; i < 4; i++) rd[i] = $urandom;
        rd_ar(1, 32'h00004010);
        rd_beats(RD_LINE, rd, 1, 1'b1);
        wr_run(32'h00003000, RD_LINE, 4'h0, wd, 1'b0);
        wr_resp(0);

        tick();
        wd = {$urandom, $urandom, $urandom, $urandom};
        rd_req = 1'b1;
        rd_type = RD_LINE;
        rd_addr = 32'h00005000;
        wr_req = 1'b1;
        wr_type = RD_WORD;
        wr_addr = 32'h00005004;
        wr_wstrb = 4'b1100;
        wr_data = wd;
        settle();
        chk("same_cycle_rd_rdy", rd_rdy, 1);
        chk("same_cycle_wr_rdy", wr_rdy, 1);
        tick();
        rd_req = 1'b0;
        wr_req = 1'b0;
        settle();
        chk("same_cycle_arvalid", axi.arvalid, 1);
        chk("same_cycle_awvalid", axi.awvalid, 1);
        for (int i = 0; i < 4; i++) rd[i] = $urandom;
        rd_ar(0, 32'h00005000);
        rd_beats(RD_LINE, rd, 1, 1'b0);
        wr_run(32'h00005004, RD_WORD, 4'b1100, wd, 1'b0);
        wr_resp(1);

        tick();
        wd = {$urandom, $urandom, $urandom, $urandom};
        wr_issue(32'h00006000, RD_LINE, 4'h0, wd);
        tick();
        rd_issue(32'h00007000, RD_LINE);
        rd_ar(0, 32'h00007000);
        for (int i = 0; i < 2; i++) begin
            axi.rvalid = 1'b1;
            axi.rdata = 32'hB0 + i;
            axi.rlast = 1'b0;
            settle();
            chk("pre_rst_ret_data", ret_data, 32'hB0 + i);
            tick();
        end
        axi.rdata = 32'hB2;
        reset = 1'b1;
        settle();
        chk("mid_rst_rd_rdy", rd_rdy, 0);
        chk("mid_rst_wr_rdy", wr_rdy, 0);
        tick();
        reset = 1'b0;
        settle();
        chk("post_rst_arvalid", axi.arvalid, 0);
        chk("post_rst_awvalid", axi.awvalid, 0);
        chk("post_rst_wvalid", axi.wvalid, 0);
        chk("post_rst_ret_valid", ret_valid, 0);
        chk("post_rst_rready", axi.rready, 0);
        axi.rvalid = 1'b0;
        settle();
        chk("post_rst_rd_rdy", rd_rdy, 1);
        chk("post_rst_wr_rdy", wr_rdy, 1);

        for (int it = 0; it < 10; it++) begin
            t = types[$urandom_range(0, 4)];
            a = {$urandom_range(0, 32'hffff), 12'h0, 4'h0};
            if (t == RD_LINE) a[3:0] = 4'h0;
            else a[3:0] = 4'(4 * $urandom_range(0, 3));
            tick();
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 4; i++) rd[i] = $urandom;
                rd_issue(a, t);
                rd_ar($urandom_range(0, 3), a);
                rd_beats(t, rd, 2, 1'b1);
            end else begin
                wd = {$urandom, $urandom, $urandom, $urandom};
                wr_issue(a, t, 4'($urandom), wd);
                wr_run(a, t, wr_wstrb, wd, 1'($urandom_range(0, 1)));
                wr_resp($urandom_range(0, 3));
            end
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
